lr2: RTL and testbench

Four-bit loadable up/down sequence counter with count enable. Standalone lab-level block: the registered value drives `SEQ` directly for display or downstream logic. All state changes occur on the rising edge of `CLK`.

---
 rtl/lr2_pkg.sv | 29 ++
 rtl/lr2_if.sv | 30 +++
 rtl/lr2.sv | 36 +++
 tb/tb_lr2.sv | 116 +++++++++++
 4 files changed

// File: rtl/lr2_pkg.sv
// rtl/lr2_pkg.sv - shared width constant and operation decode for the lr2 counter
package lr2_pkg;

    localparam int LR2_WIDTH = 4;

    typedef enum logic [2:0] {
        OP_CLEAR,
        OP_LOAD,
        OP_INC,
        OP_DEC,
        OP_HOLD
    } lr2_op_e;

    // Resolves the control inputs into a single operation, highest priority first.
    function automatic lr2_op_e lr2_decode(input logic rst, input logic load,
                                           input logic ce, input logic up);
        if (!rst)
            return OP_CLEAR;
        else if (load)
            return OP_LOAD;
        else if (ce && up)
            return OP_INC;
        else if (ce)
            return OP_DEC;
        else
            return OP_HOLD;
    endfunction

endpackage

// File: rtl/lr2_if.sv
// rtl/lr2_if.sv - control, load data and sequence output bundle of the lr2 counter
interface lr2_if
    import lr2_pkg::*;
#(
    parameter int WIDTH = LR2_WIDTH
) ();

    logic             CE;
    logic             LOAD;
    logic             UP;
    logic [WIDTH-1:0] DAT_I;
    logic [WIDTH-1:0] SEQ;

    modport master (
        output CE,
        output LOAD,
        output UP,
        output DAT_I,
        input  SEQ
    );

    modport slave (
        input  CE,
        input  LOAD,
        input  UP,
        input  DAT_I,
        output SEQ
    );

endinterface

// File: rtl/lr2.sv
// rtl/lr2.sv - loadable up/down sequence counter with count enable
module lr2
    import lr2_pkg::*;
#(
    parameter int WIDTH = LR2_WIDTH
) (
    input logic  CLK,
    input logic  RST,
    lr2_if.slave bus
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    lr2_op_e          op;

    assign op = lr2_decode(RST, bus.LOAD, bus.CE, bus.UP);

    // Wrap in both directions falls out of WIDTH-bit unsigned arithmetic.
    always_comb begin
        cnt_next = cnt;
        case (op)
            OP_CLEAR: cnt_next = '0;
            OP_LOAD:  cnt_next = bus.DAT_I;
            OP_INC:   cnt_next = cnt + WIDTH'(1);
            OP_DEC:   cnt_next = cnt - WIDTH'(1);
            default:  cnt_next = cnt;
        endcase
    end

    always_ff @(posedge CLK) begin
        cnt <= cnt_next;
    end

    assign bus.SEQ = cnt;

endmodule

// File: tb/tb_lr2.sv
// tb/tb_lr2.sv - scoreboard bench for lr2 with directed and random stimulus
module tb_lr2;

    logic CLK;
    logic RST;

    lr2_if #(.WIDTH(4)) bus ();

    lr2 #(.WIDTH(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [3:0] exp_q[$];
    int         model;
    int         n_checks;
    int         n_fail;

    // Reference: value after the edge, from the priority rules with plain integer arithmetic.
    task automatic step(input bit r, input bit l, input bit c, input bit u, input int d);
        @(negedge CLK);
        RST       = r;
        bus.LOAD  = l;
        bus.CE    = c;
        bus.UP    = u;
        bus.DAT_I = d[3:0];
        if (!r)
            model = 0;
        else if (l)
            model = d % 16;
        else if (c && u)
            model = (model + 1) % 16;
        else if (c)
            model = (model + 16 - 1) % 16;
        exp_q.push_back(model[3:0]);
    endtask

    always begin
        @(posedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.SEQ !== e) begin
                n_fail++;
                $display("FAIL seq_check#%0d: SEQ=%h expected=%h", n_checks, bus.SEQ, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = 0;
        RST = 1'b0; bus.LOAD = 1'b0; bus.CE = 1'b0; bus.UP = 1'b0; bus.DAT_I = '0;

        // reset with counting requested, then release
        repeat (2) step(0, 0, 1, 1, 0);
        repeat (3) step(1, 0, 1, 1, 0);

        // up-count wrap from reset
        step(0, 0, 1, 1, 0);
        repeat (17) step(1, 0, 1, 1, 0);

        // down-count wrap from 2
        step(1, 1, 0, 0, 2);
        repeat (4) step(1, 0, 1, 0, 0);

        // enable hold at 7 with UP toggling
        step(1, 1, 0, 0, 7);
        for (int i = 0; i < 5; i++) step(1, 0, 0, i[0], 0);

        // load with CE low, then load beating an up-count, then count on
        step(1, 1, 0, 0, 'hA);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 'hA);
        step(1, 0, 1, 1, 0);

        // held load tracks DAT_I
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0, 3 * i + 1);

        // reset beats load
        step(0, 1, 1, 1, 'hA);
        step(1, 0, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15));
        end

        @(negedge CLK);
        bus.CE = 1'b0; bus.LOAD = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
